// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction-store boot loader.
package instr_loader_pkg;

    // Frame parser states, in frame order.
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_CHK,
        S_DONE,
        S_ERROR
    } ldr_state_t;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

    // A new frame may only begin from a resting state.
    function automatic logic can_start(input ldr_state_t s);
        return (s == S_IDLE) || (s == S_DONE) || (s == S_ERROR);
    endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-store write port of the boot loader.
interface instr_loader_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int BYTE_WIDTH    = 8
);
    logic                     start_i;
    logic [BYTE_WIDTH-1:0]    byte_i;
    logic                     byte_valid_i;
    logic                     byte_ready_o;
    logic                     we_o;
    logic [ADDRESS_WIDTH-1:0] waddr_o;
    logic [ADDRESS_WIDTH-1:0] wdata_o;

    // Loader side: consumes the stream, drives the store.
    modport slave (
        input  start_i,
        input  byte_i,
        input  byte_valid_i,
        output byte_ready_o,
        output we_o,
        output waddr_o,
        output wdata_o
    );

    // Host side: produces the stream, observes the store writes.
    modport master (
        output start_i,
        output byte_i,
        output byte_valid_i,
        input  byte_ready_o,
        input  we_o,
        input  waddr_o,
        input  wdata_o
    );
endinterface

// File: rtl/instr_loader_packer.sv
// Packs accepted payload bytes little-endian into words and keeps the
// running XOR checksum. word_ready_o marks the accept that completes a word;
// word_o then already contains that final byte.
module instr_loader_packer
    import instr_loader_pkg::*;
#(
    parameter int BYTE_WIDTH = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    input  logic                                 clear_i,
    input  logic                                 accept_i,
    input  logic [BYTE_WIDTH-1:0]                byte_i,
    output logic                                 word_ready_o,
    output logic [BYTES_PER_WORD*BYTE_WIDTH-1:0] word_o,
    output logic [BYTE_WIDTH-1:0]                checksum_o
);
    localparam int WORD_W = BYTES_PER_WORD * BYTE_WIDTH;

    logic [LANE_W-1:0]     lane_q, lane_d;
    logic [WORD_W-1:0]     word_q, word_d;
    logic [BYTE_WIDTH-1:0] chk_q,  chk_d;
    logic [WORD_W-1:0]     word_shifted;

    // New bytes enter at the top, so the first byte ends up in bits [7:0].
    assign word_shifted = {byte_i, word_q[WORD_W-1:BYTE_WIDTH]};

    // Next-state for lane counter, shift register and checksum.
    always_comb begin
        // NOTE: every _d starts from its _q so no path leaves it unassigned; that is what keeps this combinational instead of a latch.
        lane_d = lane_q;
        word_d = word_q;
        chk_d  = chk_q;
        if (clear_i) begin
            lane_d = '0;
            word_d = '0;
            chk_d  = '0;
        end else if (accept_i) begin
            lane_d = lane_q + LANE_W'(1);
            word_d = word_shifted;
            chk_d  = chk_q ^ byte_i;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values regardless of statement order.
        if (!rst_n_i) begin
            lane_q <= '0;
            word_q <= '0;
            chk_q  <= '0;
        end else begin
            lane_q <= lane_d;
            word_q <= word_d;
            chk_q  <= chk_d;
        end
    end

    assign word_ready_o = accept_i && (lane_q == LANE_W'(BYTES_PER_WORD - 1));
    assign word_o       = word_shifted;
    assign checksum_o   = chk_q;

endmodule

// File: rtl/instr_loader.sv
// Boot-time instruction-store writer: parses LEN/payload/CHK frames, writes
// packed words at byte addresses 0,4,8,... and releases the CPU only after a
// frame with a matching checksum.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int BYTE_WIDTH    = 8,
    parameter int MEM_WORDS     = 1024
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    instr_loader_if.slave  bus,
    output logic           cpu_hold_o,
    output logic           busy_o,
    output logic           done_o,
    output logic           err_o
);
    localparam int LEN_W  = LEN_BYTES * BYTE_WIDTH;
    localparam int WORD_W = BYTES_PER_WORD * BYTE_WIDTH;

    ldr_state_t               state_q, state_d;
    logic [LEN_W-1:0]         len_q, len_d;
    logic [LEN_W-1:0]         word_idx_q, word_idx_d;
    logic                     we_q, we_d;
    logic [ADDRESS_WIDTH-1:0] waddr_q, waddr_d;
    logic [ADDRESS_WIDTH-1:0] wdata_q, wdata_d;

    logic                     byte_ready;
    logic                     accept;
    logic                     start_ok;
    logic                     data_accept;
    logic [LEN_W-1:0]         len_full;
    logic                     len_too_big;
    logic                     len_zero;
    logic                     last_word;
    logic                     word_ready;
    logic [WORD_W-1:0]        packed_word;
    logic [BYTE_WIDTH-1:0]    checksum;

    assign accept      = bus.byte_valid_i && byte_ready;
    assign start_ok    = bus.start_i && can_start(state_q);
    assign data_accept = accept && (state_q == S_DATA);

    // Full length as it will be once the LEN_HI byte is taken.
    assign len_full    = {bus.byte_i, len_q[BYTE_WIDTH-1:0]};
    assign len_too_big = 32'(len_full) > 32'(MEM_WORDS);
    assign len_zero    = (len_full == '0);
    assign last_word   = (word_idx_q + LEN_W'(1)) == len_q;

    instr_loader_packer #(
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_packer (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .clear_i      (start_ok),
        .accept_i     (data_accept),
        .byte_i       (bus.byte_i),
        .word_ready_o (word_ready),
        .word_o       (packed_word),
        .checksum_o   (checksum)
    );

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (bus.start_i) state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (accept) state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (accept) begin
                    if (len_too_big)   state_d = S_ERROR;
                    else if (len_zero) state_d = S_CHK;
                    else               state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (word_ready) state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d = last_word ? S_CHK : S_DATA;
            end
            S_CHK: begin
                if (accept) state_d = (bus.byte_i == checksum) ? S_DONE : S_ERROR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state only.
    always_comb begin
        byte_ready = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        err_o      = 1'b0;
        cpu_hold_o = 1'b1;
        case (state_q)
            S_LEN_LO, S_LEN_HI, S_DATA, S_CHK: begin
                byte_ready = 1'b1;
                busy_o     = 1'b1;
            end
            S_WRITE: busy_o = 1'b1;
            S_DONE: begin
                done_o     = 1'b1;
                cpu_hold_o = 1'b0;
            end
            S_ERROR: err_o = 1'b1;
            default: ;
        endcase
    end

    // Length capture, word index and write-port next values.
    always_comb begin
        len_d      = len_q;
        word_idx_d = word_idx_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        if (start_ok) begin
            len_d      = '0;
            word_idx_d = '0;
        end
        if (accept && (state_q == S_LEN_LO)) begin
            len_d = {len_q[LEN_W-1:BYTE_WIDTH], bus.byte_i};
        end
        if (accept && (state_q == S_LEN_HI)) begin
            len_d = len_full;
        end
        // Register the write on the completing accept so it appears during WRITE.
        if (word_ready) begin
            we_d    = 1'b1;
            waddr_d = ADDRESS_WIDTH'({word_idx_q, 2'b00});
            wdata_d = ADDRESS_WIDTH'(packed_word);
        end
        if (state_q == S_WRITE) begin
            word_idx_d = word_idx_q + LEN_W'(1);
        end
    end

    // Datapath and write-port registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            len_q      <= '0;
            word_idx_q <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign bus.byte_ready_o = byte_ready;
    assign bus.we_o         = we_q;
    assign bus.waddr_o      = waddr_q;
    assign bus.wdata_o      = wdata_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: frame table plus hand-written
// sequences, with a write scoreboard fed by the stimulus side.
module tb_instr_loader;

    localparam int MEM_WORDS = 1024;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [15:0] len;
        logic [7:0]  chk_flip;
        bit          gaps;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    logic clk;
    logic rst_n;
    logic cpu_hold, busy, done, err;

    int n_checks = 0;
    int n_pass   = 0;

    wr_t         sb[$];
    logic [31:0] payload [0:MEM_WORDS-1];
    vec_t        vecs [7];

    instr_loader_if #(.ADDRESS_WIDTH(32), .BYTE_WIDTH(8)) bus ();

    instr_loader #(
        .ADDRESS_WIDTH (32),
        .BYTE_WIDTH    (8),
        .MEM_WORDS     (MEM_WORDS)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .bus        (bus.slave),
        .cpu_hold_o (cpu_hold),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Scoreboard: every write pulse must match the oldest queued word.
    always @(negedge clk) begin
        if (bus.we_o === 1'b1) begin
            wr_t w;
            check("ready low in WRITE", bus.byte_ready_o, 1'b0);
            check("write was expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                w = sb.pop_front();
                check("write addr", bus.waddr_o, w.addr);
                check("write data", bus.wdata_o, w.data);
            end
        end
    end

    // Offer one byte, optionally after a random idle gap; returns on the
    // falling edge after the accepting rising edge.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int waitc;
        int g;
        if (gaps) begin
            g = $urandom_range(0, 2);
            bus.byte_valid_i = 1'b0;
            repeat (g) @(negedge clk);
        end
        bus.byte_i       = b;
        bus.byte_valid_i = 1'b1;
        waitc = 0;
        while (bus.byte_ready_o !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 20) check("byte accept timeout", 32'(waitc), 0);
        else @(negedge clk);
    endtask

    // Drive a whole frame from payload[]. stop_after >= 0 abandons the frame
    // after that many payload bytes. use_fixed sends chk_arg as the CHK byte,
    // otherwise the bench checksum XOR chk_arg.
    task automatic do_frame(input logic [15:0] len, input bit use_fixed,
                            input logic [7:0] chk_arg, input bit gaps,
                            input bit poke_start, input int stop_after);
        logic [7:0] x;
        logic [7:0] b;
        int         sent;
        wr_t        w;
        x    = 8'h00;
        sent = 0;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        check("start clears done", done, 1'b0);
        check("start clears err", err, 1'b0);
        check("busy in frame", busy, 1'b1);
        check("hold in frame", cpu_hold, 1'b1);
        send_byte(len[7:0], gaps);
        send_byte(len[15:8], gaps);
        if (len > MEM_WORDS) begin
            bus.byte_valid_i = 1'b0;
            return;
        end
        for (int wi = 0; wi < int'(len); wi++) begin
            for (int k = 0; k < 4; k++) begin
                if (stop_after >= 0 && sent == stop_after) begin
                    bus.byte_valid_i = 1'b0;
                    return;
                end
                b = payload[wi][8*k +: 8];
                x = x ^ b;
                if (k == 3) begin
                    w.addr = 32'(wi) << 2;
                    w.data = payload[wi];
                    sb.push_back(w);
                end
                if (poke_start && sent == 0) bus.start_i = 1'b1;
                send_byte(b, gaps);
                bus.start_i = 1'b0;
                sent++;
                if (k == 3) check("write latency", bus.we_o, 1'b1);
            end
        end
        send_byte(use_fixed ? chk_arg : (x ^ chk_arg), gaps);
        bus.byte_valid_i = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst byte_ready", bus.byte_ready_o, 1'b0);
        check("rst we", bus.we_o, 1'b0);
        check("rst waddr", bus.waddr_o, 32'h0);
        check("rst wdata", bus.wdata_o, 32'h0);
        check("rst cpu_hold", cpu_hold, 1'b1);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst err", err, 1'b0);
    endtask

    task automatic check_end(input string tag, input bit exp_done, input bit exp_err);
        check({tag, " done"}, done, exp_done);
        check({tag, " err"}, err, exp_err);
        check({tag, " cpu_hold"}, cpu_hold, !exp_done);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " writes drained"}, 32'(sb.size()), 0);
    endtask

    task automatic load_spec_payload();
        payload[0] = 32'h0050_0513;
        payload[1] = 32'h00A0_0593;
    endtask

    initial begin
        // len, chk_flip, gaps, exp_done, exp_err
        vecs[0] = '{16'd1,    8'h00, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{16'd3,    8'h01, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{16'd0,    8'h00, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h0401, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{16'd1024, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{16'd5,    8'h00, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{16'd4,    8'h80, 1'b0, 1'b0, 1'b1};

        rst_n            = 1'b0;
        bus.start_i      = 1'b0;
        bus.byte_i       = 8'h00;
        bus.byte_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        @(negedge clk);

        // Reference frame, valid held high throughout.
        load_spec_payload();
        do_frame(16'd2, 1'b1, 8'h70, 1'b0, 1'b0, -1);
        check_end("good frame", 1'b1, 1'b0);

        // Same frame with random valid gaps.
        do_frame(16'd2, 1'b1, 8'h70, 1'b1, 1'b0, -1);
        check_end("good frame gaps", 1'b1, 1'b0);

        // Bad checksum: both writes still happen.
        do_frame(16'd2, 1'b1, 8'h71, 1'b1, 1'b0, -1);
        check_end("bad checksum", 1'b0, 1'b1);

        // start_i during DATA must be ignored.
        do_frame(16'd2, 1'b1, 8'h70, 1'b0, 1'b1, -1);
        check_end("start ignored", 1'b1, 1'b0);

        // Table of random-payload frames.
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < MEM_WORDS; j++) payload[j] = $urandom;
            do_frame(vecs[i].len, 1'b0, vecs[i].chk_flip, vecs[i].gaps, 1'b0, -1);
            check_end($sformatf("vec%0d", i), vecs[i].exp_done, vecs[i].exp_err);
        end

        // Reset in the middle of a frame, then a clean reload.
        load_spec_payload();
        do_frame(16'd2, 1'b1, 8'h70, 1'b0, 1'b0, 6);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        @(negedge clk);
        do_frame(16'd2, 1'b1, 8'h70, 1'b1, 1'b0, -1);
        check_end("reload after reset", 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        check("no stray writes", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
